// File: rtl/acc_stack_if.sv
// Bus bundle between the control/datapath side and the accumulator-with-stack.
// The master drives the control word and the ALU/MBR data. The slave returns
// the accumulator copies and the status bits.
interface acc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) ();

  logic [31:0]      control_signal;
  logic [WIDTH-1:0] from_ALU;
  logic [WIDTH-1:0] from_MBR;
  logic [WIDTH-1:0] to_ALU;
  logic [WIDTH-1:0] to_MBR;
  logic [WIDTH-1:0] BUFF_ACC;
  logic             flag;
  logic             zero_flag;
  logic [CW-1:0]    stk_count;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output control_signal, from_ALU, from_MBR,
    input  to_ALU, to_MBR, BUFF_ACC, flag, zero_flag,
           stk_count, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  control_signal, from_ALU, from_MBR,
    output to_ALU, to_MBR, BUFF_ACC, flag, zero_flag,
           stk_count, stk_full, stk_empty, stk_err
  );

endinterface

// File: rtl/acc_stack.sv
// Accumulator for the microcoded CPU datapath, with a LIFO save stack.
// A one-hot control word selects the accumulator source: pop, ALU, MBR or clear.
// The same word carries push, pop and exchange for the stack.
// A sticky error bit records any overflow or underflow.
module acc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic        clk,
  input logic        rst_n,
  acc_stack_if.slave bus
);

  // Stack index width; a single-entry stack still needs one address bit.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             alu_ld, mbr_ld, clr_ld;
  logic             push, pop, clr_err;
  logic             empty, full;
  logic             pop_ok, push_ok, xchg, bad_op;
  logic [AW-1:0]    wr_idx, top_idx, mem_idx;
  logic             mem_we;
  logic             unused_ctrl;

  // Control bits that do not select any micro-operation here.
  assign unused_ctrl = ^{bus.control_signal[31:22], bus.control_signal[13],
                         bus.control_signal[7:0]};

  // Decode the control word and resolve stack legality and the accumulator source.
  always_comb begin
    alu_ld  = bus.control_signal[9]  | bus.control_signal[11] |
              bus.control_signal[12] | (|bus.control_signal[18:14]);
    mbr_ld  = bus.control_signal[10];
    clr_ld  = bus.control_signal[8];
    push    = bus.control_signal[19];
    pop     = bus.control_signal[20];
    clr_err = bus.control_signal[21];

    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    wr_idx  = AW'(cnt_q);
    top_idx = AW'(cnt_q - CW'(1));

    // A pop on a non-empty stack is valid, on its own or as half of an exchange.
    pop_ok  = pop & ~empty;
    push_ok = push & ~pop & ~full;
    xchg    = push & pop & ~empty;
    bad_op  = (push & ~pop & full) | (pop & empty);

    mem_we  = push_ok | xchg;
    mem_idx = push_ok ? wr_idx : top_idx;

    // An invalid pop does not claim the accumulator; the lower-priority loads still apply.
    acc_d = acc_q;
    if (pop_ok)      acc_d = mem_q[top_idx];
    else if (alu_ld) acc_d = bus.from_ALU;
    else if (mbr_ld) acc_d = bus.from_MBR;
    else if (clr_ld) acc_d = '0;

    cnt_d = cnt_q;
    if (push_ok)              cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push) cnt_d = cnt_q - CW'(1);

    // A new error in the same cycle as a clear leaves the flag set.
    err_d = err_q;
    if (bad_op)       err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  // Accumulator, stack depth and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage. Push and exchange both save the accumulator value from before the edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= acc_q;
  end

  assign bus.to_ALU    = acc_q;
  assign bus.to_MBR    = acc_q;
  assign bus.BUFF_ACC  = acc_q;
  assign bus.flag      = ~acc_q[WIDTH-1];
  assign bus.zero_flag = (acc_q == '0);
  assign bus.stk_count = cnt_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err_q;

endmodule

// File: tb/tb_acc_stack.sv
// Directed bench for acc_stack. The main table exercises a 16-bit, depth-4 instance.
// Hand-written sequences cover asynchronous reset and an 8-bit, depth-1 instance.
module tb_acc_stack;

  localparam logic [31:0] B8  = 32'h1 << 8;
  localparam logic [31:0] B9  = 32'h1 << 9;
  localparam logic [31:0] B10 = 32'h1 << 10;
  localparam logic [31:0] B11 = 32'h1 << 11;
  localparam logic [31:0] B13 = 32'h1 << 13;
  localparam logic [31:0] B14 = 32'h1 << 14;
  localparam logic [31:0] PSH = 32'h1 << 19;
  localparam logic [31:0] POP = 32'h1 << 20;
  localparam logic [31:0] CLE = 32'h1 << 21;

  typedef struct {
    logic [31:0] cs;
    logic [15:0] alu;
    logic [15:0] mbr;
    logic [15:0] acc;
    int          cnt;
    bit          err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vt[$];

  acc_stack_if #(.WIDTH(16), .DEPTH(4)) bus16 ();
  acc_stack_if #(.WIDTH(8),  .DEPTH(1)) bus8 ();

  acc_stack #(.WIDTH(16), .DEPTH(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  acc_stack #(.WIDTH(8),  .DEPTH(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] cs, input logic [15:0] alu, input logic [15:0] mbr,
                     input logic [15:0] acc, input int cnt, input bit err);
    vt.push_back('{cs, alu, mbr, acc, cnt, err});
  endtask

  task automatic check16(input string tag, input logic [15:0] acc, input int cnt, input bit err);
    chk({tag, " to_ALU"},    32'(bus16.to_ALU),    32'(acc));
    chk({tag, " to_MBR"},    32'(bus16.to_MBR),    32'(acc));
    chk({tag, " BUFF_ACC"},  32'(bus16.BUFF_ACC),  32'(acc));
    chk({tag, " flag"},      32'(bus16.flag),      32'(!acc[15]));
    chk({tag, " zero_flag"}, 32'(bus16.zero_flag), 32'(acc == 16'h0));
    chk({tag, " stk_count"}, 32'(bus16.stk_count), 32'(cnt));
    chk({tag, " stk_full"},  32'(bus16.stk_full),  32'(cnt == 4));
    chk({tag, " stk_empty"}, 32'(bus16.stk_empty), 32'(cnt == 0));
    chk({tag, " stk_err"},   32'(bus16.stk_err),   32'(err));
  endtask

  task automatic check8(input string tag, input logic [7:0] acc, input int cnt, input bit err);
    chk({tag, " to_ALU"},    32'(bus8.to_ALU),    32'(acc));
    chk({tag, " flag"},      32'(bus8.flag),      32'(!acc[7]));
    chk({tag, " zero_flag"}, 32'(bus8.zero_flag), 32'(acc == 8'h0));
    chk({tag, " stk_count"}, 32'(bus8.stk_count), 32'(cnt));
    chk({tag, " stk_full"},  32'(bus8.stk_full),  32'(cnt == 1));
    chk({tag, " stk_empty"}, 32'(bus8.stk_empty), 32'(cnt == 0));
    chk({tag, " stk_err"},   32'(bus8.stk_err),   32'(err));
  endtask

  task automatic step16(input logic [31:0] cs, input logic [15:0] alu, input logic [15:0] mbr);
    bus16.control_signal = cs;
    bus16.from_ALU       = alu;
    bus16.from_MBR       = mbr;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic [31:0] cs, input logic [7:0] alu, input logic [7:0] mbr);
    bus8.control_signal = cs;
    bus8.from_ALU       = alu;
    bus8.from_MBR       = mbr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Load priority and clear
    add(B9 | B10 | B8, 16'h8001, 16'h1234, 16'h8001, 0, 1'b0);
    add(B10,           16'h0000, 16'h1234, 16'h1234, 0, 1'b0);
    add(B8,            16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
    // Unassigned bits are ignored
    add(B13 | 32'h1,   16'hFFFF, 16'hFFFF, 16'h0000, 0, 1'b0);
    // Fill the stack with 1..4, overflow, then drain it
    add(B9,            16'h0001, 16'h0000, 16'h0001, 0, 1'b0);
    add(PSH | B9,      16'h0002, 16'h0000, 16'h0002, 1, 1'b0);
    add(PSH | B9,      16'h0003, 16'h0000, 16'h0003, 2, 1'b0);
    add(PSH | B9,      16'h0004, 16'h0000, 16'h0004, 3, 1'b0);
    add(PSH,           16'h0000, 16'h0000, 16'h0004, 4, 1'b0);
    add(PSH,           16'h0000, 16'h0000, 16'h0004, 4, 1'b1);
    add(POP,           16'h0000, 16'h0000, 16'h0004, 3, 1'b1);
    add(POP,           16'h0000, 16'h0000, 16'h0003, 2, 1'b1);
    add(POP,           16'h0000, 16'h0000, 16'h0002, 1, 1'b1);
    add(POP,           16'h0000, 16'h0000, 16'h0001, 0, 1'b1);
    add(CLE,           16'h0000, 16'h0000, 16'h0001, 0, 1'b0);
    // An underflow lets the load fall through; clear and set collide
    add(POP | B14,     16'h00AA, 16'h0000, 16'h00AA, 0, 1'b1);
    add(CLE,           16'h0000, 16'h0000, 16'h00AA, 0, 1'b0);
    add(CLE | POP,     16'h0000, 16'h0000, 16'h00AA, 0, 1'b1);
    add(CLE,           16'h0000, 16'h0000, 16'h00AA, 0, 1'b0);
    // Exchange
    add(B9,            16'h1111, 16'h0000, 16'h1111, 0, 1'b0);
    add(PSH,           16'h0000, 16'h0000, 16'h1111, 1, 1'b0);
    add(B9,            16'h2222, 16'h0000, 16'h2222, 1, 1'b0);
    add(PSH | POP,     16'h0000, 16'h0000, 16'h1111, 1, 1'b0);
    add(POP,           16'h0000, 16'h0000, 16'h2222, 0, 1'b0);
    // Push with a simultaneous load saves the old value
    add(B9,            16'h0F0F, 16'h0000, 16'h0F0F, 0, 1'b0);
    add(PSH | B11,     16'h5555, 16'h0000, 16'h5555, 1, 1'b0);
    add(POP,           16'h0000, 16'h0000, 16'h0F0F, 0, 1'b0);
    // A valid pop overrides the MBR load and the clear
    add(B10,           16'h0000, 16'h7777, 16'h7777, 0, 1'b0);
    add(PSH,           16'h0000, 16'h0000, 16'h7777, 1, 1'b0);
    add(POP | B10 | B8, 16'h0000, 16'h9999, 16'h7777, 0, 1'b0);
    // An exchange on an empty stack is an error; the MBR load still applies
    add(PSH | POP | B10, 16'h0000, 16'h4242, 16'h4242, 0, 1'b1);
    add(CLE,           16'h0000, 16'h0000, 16'h4242, 0, 1'b0);

    rst_n = 1'b0;
    bus16.control_signal = '0; bus16.from_ALU = '0; bus16.from_MBR = '0;
    bus8.control_signal  = '0; bus8.from_ALU  = '0; bus8.from_MBR  = '0;
    #12;
    check16("init", 16'h0000, 0, 1'b0);
    check8("init8", 8'h00, 0, 1'b0);
    rst_n = 1'b1;
    #1;

    foreach (vt[i]) begin
      step16(vt[i].cs, vt[i].alu, vt[i].mbr);
      check16($sformatf("v%0d", i), vt[i].acc, vt[i].cnt, vt[i].err);
    end

    // Asynchronous reset between edges, with a push pending
    step16(POP | B9, 16'h8888, 16'h0000);
    check16("pre_rst_a", 16'h8888, 0, 1'b1);
    step16(PSH, 16'h0000, 16'h0000);
    check16("pre_rst_b", 16'h8888, 1, 1'b1);
    bus16.control_signal = PSH | B9;
    bus16.from_ALU       = 16'h3333;
    #3 rst_n = 1'b0;
    #1;
    check16("async_rst", 16'h0000, 0, 1'b0);
    bus16.control_signal = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check16("post_rst", 16'h0000, 0, 1'b0);

    // Eight-bit instance with a single-entry stack
    step8(B9, 8'h0F, 8'h00);
    check8("w8_load", 8'h0F, 0, 1'b0);
    step8(PSH | B11, 8'h55, 8'h00);
    check8("w8_pushld", 8'h55, 1, 1'b0);
    step8(PSH | B9, 8'h80, 8'h00);
    check8("w8_ovf", 8'h80, 1, 1'b1);
    step8(POP | CLE, 8'h00, 8'h00);
    check8("w8_pop", 8'h0F, 0, 1'b0);
    step8(POP | B10, 8'h00, 8'hA5);
    check8("w8_unf", 8'hA5, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
